matrix_accel_nxn: RTL and testbench

Parametrised signed-integer matrix-multiply accelerator computing C = A × B for square matrices up to N_MAX×N_MAX, with a runtime-selectable dimension. It is a memory-mapped slave on the SoC accelerator port (base 0x0200_0000) and supersedes the fixed 3×3 unit. It computes one multiply-accumulate per cycle and raises an optional completion interrupt.

---
 rtl/matrix_accel_nxn.sv | 190 +++++++++++++++++++
 tb/tb_matrix_accel_nxn.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_accel_nxn.sv
// matrix_accel_nxn: memory-mapped signed matrix multiplier C = A x B, runtime n x n (n <= N_MAX).
// Latency: one MAC per cycle, n^3 + 1 cycles from the start-write edge to done; bus acks one cycle after request.
// Backpressure: single-outstanding bus, mem_ready pulses once per request, requests seen while mem_ready=1 wait.
//
// Ports: clk/rst_n (async active-low), mem_valid/mem_write/mem_addr/mem_wdata/mem_wstrb request,
//        mem_rdata/mem_ready response, irq = done & irq_en.
// Option: define MATACC_SATURATE_EN to clamp each accumulate to the signed ACC_W range instead of wrapping.
module matrix_accel_nxn #(
  parameter int N_MAX  = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_valid,
  input  logic        mem_write,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        irq
);
  localparam int NN    = N_MAX * N_MAX;
  localparam int IW    = (NN > 1) ? $clog2(NN) : 1;
  localparam int DEPTH = 1 << IW;
  localparam int PW    = 2 * DATA_W;

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  state_t                   state;
  logic [3:0]               n, i, j, k;
  logic                     done, err, irq_en;
  logic signed [ACC_W-1:0]  acc;

  logic signed [DATA_W-1:0] a_mem [DEPTH];
  logic signed [DATA_W-1:0] b_mem [DEPTH];
  logic signed [ACC_W-1:0]  c_mem [DEPTH];

  // Bus decode: word offset [9:2], region in the top two bits of it.
  logic        accept, wr, busy, in_arr;
  logic [7:0]  word;
  logic [1:0]  region;
  logic [5:0]  off;
  logic [IW-1:0] idx;
  logic        wr_ctrl, wr_dim, wr_a, wr_b;
  logic [3:0]  dim_val;
  logic [31:0] rd_val;
  logic        unused_bits;

  assign accept  = mem_valid & ~mem_ready;
  assign wr      = accept & mem_write & (|mem_wstrb);
  assign busy    = (state != IDLE);
  assign word    = mem_addr[9:2];
  assign region  = word[7:6];
  assign off     = word[5:0];
  assign in_arr  = ({26'd0, off} < 32'(NN));
  assign idx     = off[IW-1:0];
  assign wr_ctrl = wr & (region == 2'd0) & (off == 6'd0);
  assign wr_dim  = wr & (region == 2'd0) & (off == 6'd1);
  assign wr_a    = wr & (region == 2'd1) & in_arr;
  assign wr_b    = wr & (region == 2'd2) & in_arr;
  assign unused_bits = ^{mem_addr[31:10], mem_addr[1:0]};

  assign dim_val = (mem_wdata == 32'd0)  ? 4'd1 :
                   (mem_wdata > N_MAX)   ? 4'(N_MAX) : mem_wdata[3:0];

  always_comb begin
    rd_val = 32'd0;
    case (region)
      2'd0: begin
        if (off == 6'd0)      rd_val = {28'd0, err, irq_en, done, busy};
        else if (off == 6'd1) rd_val = {28'd0, n};
      end
      2'd1: if (in_arr) rd_val = 32'(a_mem[idx]);
      2'd2: if (in_arr) rd_val = 32'(b_mem[idx]);
      default: if (in_arr) rd_val = 32'(c_mem[idx]);
    endcase
  end

  // Datapath: product of A[i][k] and B[k][j], accumulated over k.
  logic [IW-1:0]           a_idx, b_idx, c_idx;
  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] prod_ext, base, sum;
  logic                    k_last, j_last, i_last;

  assign a_idx    = IW'(int'(i) * N_MAX + int'(k));
  assign b_idx    = IW'(int'(k) * N_MAX + int'(j));
  assign c_idx    = IW'(int'(i) * N_MAX + int'(j));
  assign prod     = $signed(PW'(a_mem[a_idx])) * $signed(PW'(b_mem[b_idx]));
  assign prod_ext = ACC_W'(prod);
  assign base     = (k == 4'd0) ? '0 : acc;
  assign k_last   = (k == (n - 4'd1));
  assign j_last   = (j == (n - 4'd1));
  assign i_last   = (i == (n - 4'd1));

`ifdef MATACC_SATURATE_EN
  // One extra bit exposes overflow; clamp toward the sign of the true sum.
  logic signed [ACC_W:0] wide;
  assign wide = $signed({base[ACC_W-1], base}) + $signed({prod_ext[ACC_W-1], prod_ext});
  always_comb begin
    sum = wide[ACC_W-1:0];
    if (wide[ACC_W] != wide[ACC_W-1])
      sum = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  end
`else
  assign sum = base + prod_ext;
`endif

  // Control, status and bus response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      n         <= 4'(N_MAX);
      i         <= 4'd0;
      j         <= 4'd0;
      k         <= 4'd0;
      acc       <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      irq_en    <= 1'b0;
      mem_ready <= 1'b0;
      mem_rdata <= 32'd0;
    end else begin
      mem_ready <= accept;
      mem_rdata <= (accept && !mem_write) ? rd_val : 32'd0;

      // W1C first so that set events later in this block take priority.
      if (wr_ctrl) begin
        irq_en <= mem_wdata[2];
        if (mem_wdata[1]) done <= 1'b0;
        if (mem_wdata[3]) err  <= 1'b0;
      end
      if (wr_dim && !busy) n <= dim_val;
      if (busy && ((wr_ctrl && mem_wdata[0]) || wr_dim || wr_a || wr_b)) err <= 1'b1;

      case (state)
        IDLE: begin
          if (wr_ctrl && mem_wdata[0]) begin
            state <= COMPUTE;
            done  <= 1'b0;
            i     <= 4'd0;
            j     <= 4'd0;
            k     <= 4'd0;
          end
        end
        COMPUTE: begin
          acc <= sum;
          if (k_last) begin
            k <= 4'd0;
            if (j_last) begin
              j <= 4'd0;
              if (i_last) begin
                i     <= 4'd0;
                state <= DONE;
              end else begin
                i <= i + 4'd1;
              end
            end else begin
              j <= j + 4'd1;
            end
          end else begin
            k <= k + 4'd1;
          end
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign irq = done & irq_en;

  // Operand and result storage carry no reset.
  always_ff @(posedge clk) begin
    if (wr_a && !busy) a_mem[idx] <= mem_wdata[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (wr_b && !busy) b_mem[idx] <= mem_wdata[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (state == COMPUTE && k_last) c_mem[c_idx] <= sum;
  end

endmodule

// File: tb/tb_matrix_accel_nxn.sv
`timescale 1ns/1ps
module tb_matrix_accel_nxn;
  localparam int N = 4;
  localparam logic [31:0] BASE = 32'h0200_0000;
  localparam logic [31:0] CTRL = BASE;
  localparam logic [31:0] DIM  = BASE + 32'h4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_valid, mem_write;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] rdata32, rdata16;
  logic        ready32, ready16, irq32, irq16;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  matrix_accel_nxn #(.N_MAX(N), .DATA_W(8), .ACC_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .mem_valid(mem_valid), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(rdata32), .mem_ready(ready32), .irq(irq32));

  // Narrow-accumulator copy sees the same bus traffic.
  matrix_accel_nxn #(.N_MAX(N), .DATA_W(8), .ACC_W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .mem_valid(mem_valid), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(rdata16), .mem_ready(ready16), .irq(irq16));

  function automatic logic [31:0] a_addr(input int r, input int c);
    return BASE + 32'h100 + 32'(4 * (r * N + c));
  endfunction
  function automatic logic [31:0] b_addr(input int r, input int c);
    return BASE + 32'h200 + 32'(4 * (r * N + c));
  endfunction
  function automatic logic [31:0] c_addr(input int r, input int c);
    return BASE + 32'h300 + 32'(4 * (r * N + c));
  endfunction

  task automatic bus_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                          output logic [31:0] rd, output logic [31:0] rd16);
    int t;
    @(negedge clk);
    mem_valid = 1'b1; mem_write = wr; mem_addr = addr; mem_wdata = data;
    mem_wstrb = wr ? 4'hF : 4'h0;
    t = 0;
    do begin
      @(posedge clk); #1; t++;
    end while (!ready32 && t < 20);
    rd = rdata32; rd16 = rdata16;
    if (!ready32) begin
      compared++; mismatched++;
      $display("FAIL bus_timeout addr=%h ready=%b required=1", addr, ready32);
    end
    mem_valid = 1'b0; mem_write = 1'b0;
  endtask

  task automatic bus_wr(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] d1, d2;
    bus_xfer(1'b1, addr, data, d1, d2);
  endtask

  task automatic bus_rd(input logic [31:0] addr, output logic [31:0] d);
    logic [31:0] d2;
    bus_xfer(1'b0, addr, 32'd0, d, d2);
  endtask

  task automatic wait_done();
    logic [31:0] v;
    int t = 0;
    do begin
      bus_rd(CTRL, v); t++;
    end while (!v[1] && t < 200);
    if (!v[1]) begin
      compared++; mismatched++;
      $display("FAIL done_timeout ctrl=%h required bit1 set", v);
    end
  endtask

  task automatic load_identity(input int s);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        bus_wr(a_addr(r, c), (r == c) ? 32'd1 : 32'd0);
        bus_wr(b_addr(r, c), 32'(s * (4 * r + c - 8)));
      end
  endtask

  task automatic check_identity(input string name, input int s);
    logic [31:0] v, e;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        bus_rd(c_addr(r, c), v);
        e = 32'(s * (4 * r + c - 8));
        compared++;
        if (v !== e) begin
          mismatched++;
          $display("FAIL %s C[%0d][%0d] got=%h required=%h", name, r, c, v, e);
        end
      end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    compared++;
    if ({ready32, irq32, rdata32} !== 34'd0) begin
      mismatched++;
      $display("FAIL reset_pins ready=%b irq=%b rdata=%h required 0", ready32, irq32, rdata32);
    end
    bus_rd(CTRL, v);
    compared++;
    if (v !== 32'd0) begin mismatched++; $display("FAIL reset_ctrl got=%h required=0", v); end
    @(posedge clk); #1;
    compared++;
    if (ready32 !== 1'b0) begin mismatched++; $display("FAIL ready_single_pulse got=%b required=0", ready32); end
    bus_rd(DIM, v);
    compared++;
    if (v !== 32'd4) begin mismatched++; $display("FAIL reset_dim got=%h required=4", v); end
    bus_rd(BASE + 32'h8, v);
    compared++;
    if (v !== 32'd0) begin mismatched++; $display("FAIL unmapped_reg got=%h required=0", v); end
    bus_rd(BASE + 32'h3F0, v);
    compared++;
    if (v !== 32'd0) begin mismatched++; $display("FAIL unmapped_c got=%h required=0", v); end
  endtask

  task automatic test_dim_clamp();
    logic [31:0] wv [3] = '{32'd0, 32'd9, 32'd3};
    logic [31:0] ev [3] = '{32'd1, 32'd4, 32'd3};
    logic [31:0] v;
    for (int t = 0; t < 3; t++) begin
      bus_wr(DIM, wv[t]);
      bus_rd(DIM, v);
      compared++;
      if (v !== ev[t]) begin
        mismatched++;
        $display("FAIL dim_clamp wrote=%0d got=%h required=%h", wv[t], v, ev[t]);
      end
    end
  endtask

  task automatic test_basic_3x3();
    int exp_c [9] = '{30, 24, 18, 84, 69, 54, 138, 114, 90};
    logic [31:0] v;
    int cnt;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        bus_wr(a_addr(r, c), 32'(r * 3 + c + 1));
        bus_wr(b_addr(r, c), 32'(9 - (r * 3 + c)));
      end
    bus_wr(DIM, 32'd3);
    bus_wr(CTRL, 32'h5);       // start with irq_en
    cnt = 0;
    do begin
      @(posedge clk); #1; cnt++;
    end while (!irq32 && cnt < 60);
    compared++;
    if (cnt !== 28) begin mismatched++; $display("FAIL start_latency cycles=%0d required=28", cnt); end
    bus_rd(CTRL, v);
    compared++;
    if (v !== 32'h6) begin mismatched++; $display("FAIL ctrl_done got=%h required=6", v); end
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        bus_rd(c_addr(r, c), v);
        compared++;
        if (v !== 32'(exp_c[r * 3 + c])) begin
          mismatched++;
          $display("FAIL basic_3x3 C[%0d][%0d] got=%0d required=%0d", r, c, v, exp_c[r * 3 + c]);
        end
      end
    bus_wr(CTRL, 32'h6);       // W1C done, keep irq_en
    #1;
    compared++;
    if (irq32 !== 1'b0) begin mismatched++; $display("FAIL irq_clear got=%b required=0", irq32); end
    bus_wr(CTRL, 32'h0);
  endtask

  task automatic test_identity_4x4();
    bus_wr(DIM, 32'd4);
    load_identity(1);
    bus_wr(CTRL, 32'h1);
    wait_done();
    check_identity("identity", 1);
  endtask

  task automatic test_neg_full();
    logic [31:0] v, v16, e16;
`ifdef MATACC_SATURATE_EN
    e16 = 32'd32767;
`else
    e16 = 32'd0;
`endif
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        bus_wr(a_addr(r, c), 32'h80);
        bus_wr(b_addr(r, c), 32'h80);
      end
    bus_rd(a_addr(0, 0), v);
    compared++;
    if (v !== 32'hFFFF_FF80) begin mismatched++; $display("FAIL a_sign_ext got=%h required=ffffff80", v); end
    bus_wr(CTRL, 32'h3);       // start and clear a stale done
    wait_done();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        bus_xfer(1'b0, c_addr(r, c), 32'd0, v, v16);
        compared++;
        if (v !== 32'd65536) begin
          mismatched++;
          $display("FAIL neg_acc32 C[%0d][%0d] got=%0d required=65536", r, c, v);
        end
        compared++;
        if (v16 !== e16) begin
          mismatched++;
          $display("FAIL neg_acc16 C[%0d][%0d] got=%h required=%h", r, c, v16, e16);
        end
      end
  endtask

  task automatic test_busy_err();
    logic [31:0] v;
    bus_wr(DIM, 32'd2);
    bus_wr(CTRL, 32'h7);       // start, clear done, irq_en
    bus_wr(CTRL, 32'h5);       // start while busy -> err
    bus_wr(a_addr(0, 0), 32'd0);
    bus_wr(DIM, 32'd3);
    wait_done();
    compared++;
    if (irq32 !== 1'b1) begin mismatched++; $display("FAIL irq_with_done got=%b required=1", irq32); end
    bus_rd(CTRL, v);
    compared++;
    if (v !== 32'hE) begin mismatched++; $display("FAIL ctrl_err got=%h required=e", v); end
    bus_rd(DIM, v);
    compared++;
    if (v !== 32'd2) begin mismatched++; $display("FAIL dim_busy_ignored got=%h required=2", v); end
    bus_rd(a_addr(0, 0), v);
    compared++;
    if (v !== 32'hFFFF_FF80) begin mismatched++; $display("FAIL a_busy_ignored got=%h required=ffffff80", v); end
    bus_rd(c_addr(1, 1), v);
    compared++;
    if (v !== 32'd32768) begin mismatched++; $display("FAIL busy_result got=%0d required=32768", v); end
    bus_rd(c_addr(2, 2), v);
    compared++;
    if (v !== 32'd65536) begin mismatched++; $display("FAIL c_outside_n got=%0d required=65536", v); end
    bus_wr(CTRL, 32'hC);       // clear err, keep irq_en
    bus_rd(CTRL, v);
    compared++;
    if (v !== 32'h6) begin mismatched++; $display("FAIL err_clear got=%h required=6", v); end
    bus_wr(CTRL, 32'h6);
    #1;
    compared++;
    if (irq32 !== 1'b0) begin mismatched++; $display("FAIL irq_w1c got=%b required=0", irq32); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] v;
    bus_wr(DIM, 32'd4);
    load_identity(1);
    bus_wr(CTRL, 32'h5);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    compared++;
    if ({ready32, irq32} !== 2'b00) begin mismatched++; $display("FAIL abort_pins ready=%b irq=%b required 0", ready32, irq32); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus_rd(CTRL, v);
    compared++;
    if (v !== 32'd0) begin mismatched++; $display("FAIL abort_ctrl got=%h required=0", v); end
    bus_rd(DIM, v);
    compared++;
    if (v !== 32'd4) begin mismatched++; $display("FAIL abort_dim got=%h required=4", v); end
    load_identity(-1);
    bus_wr(CTRL, 32'h1);
    wait_done();
    check_identity("restart", -1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; mem_valid = 1'b0; mem_write = 1'b0;
    mem_addr = 32'd0; mem_wdata = 32'd0; mem_wstrb = 4'h0;
    repeat (3) @(negedge clk);
    #1;
    test_reset_pins_early: begin end
    rst_n = 1'b1;
    test_reset();
    test_dim_clamp();
    test_basic_3x3();
    test_identity_4x4();
    test_neg_full();
    test_busy_err();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
